// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding data-memory controller between the core's
// memory stage and a word-wide synchronous SRAM with byte enables and a
// fixed number of wait states. Illegal requests are answered with an error
// response and never reach the SRAM.
module dmem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    localparam int SA_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_r_enable,
    input  logic              dmem_w_enable,
    input  logic [1:0]        dmem_w_size,
    input  logic [DATA_W-1:0] dmem_w_data,
    output logic [DATA_W-1:0] dmem_r_data,
    output logic              dmem_ready,
    output logic              dmem_err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [SA_W-1:0]   sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // First byte address past the end of the SRAM, one bit wider than the
    // core address so that the comparison cannot wrap.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(64'(DEPTH_WORDS) << 2);
    localparam logic [3:0]      WAIT_CNT   = 4'(WAIT_STATES);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                is_load_q;
    logic                ready_q;
    logic                err_q;
    logic                rd_gate_q;
    logic                sram_en_q;
    logic                sram_we_q;
    logic [3:0]          sram_be_q;
    logic [SA_W-1:0]     sram_addr_q;
    logic [DATA_W-1:0]   sram_wdata_q;

    logic                req_d;
    logic                is_store_d;
    logic                err_d;
    logic [3:0]          be_d;
    logic [DATA_W-1:0]   wdata_d;

    assign req_d      = dmem_r_enable | dmem_w_enable;
    assign is_store_d = dmem_w_enable & ~dmem_r_enable;

    // Request validation and byte-enable generation for the sampled request.
    always_comb begin
        err_d = 1'b0;
        be_d  = 4'b0000;
        if (dmem_r_enable && dmem_w_enable) begin
            err_d = 1'b1;
        end else if (dmem_w_enable) begin
            case (dmem_w_size)
                SZ_BYTE: be_d = 4'b0001 << dmem_addr[1:0];
                SZ_HALF: begin
                    if (dmem_addr[0]) err_d = 1'b1;
                    else              be_d  = 4'b0011 << dmem_addr[1:0];
                end
                SZ_WORD: begin
                    if (dmem_addr[1:0] != 2'b00) err_d = 1'b1;
                    else                         be_d  = 4'b1111;
                end
                default: err_d = 1'b1;
            endcase
        end
        if ({1'b0, dmem_addr} >= ADDR_LIMIT) err_d = 1'b1;
    end

    // Lane replication: each SRAM byte lane picks the store byte that would
    // land in it, so the byte enables alone decide what is written.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_d[8*gi +: 8] =
            (dmem_w_size == SZ_BYTE) ? dmem_w_data[7:0] :
            (dmem_w_size == SZ_HALF) ? dmem_w_data[8*(gi % 2) +: 8] :
                                       dmem_w_data[8*gi +: 8];
    end

    // Transaction FSM; every output is a register updated on the transition
    // into the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            is_load_q    <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            rd_gate_q    <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= 4'b0000;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            rd_gate_q    <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= 4'b0000;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        if (err_d) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q      <= ACCESS;
                            is_load_q    <= ~is_store_d;
                            sram_en_q    <= 1'b1;
                            sram_we_q    <= is_store_d;
                            sram_be_q    <= be_d;
                            sram_addr_q  <= dmem_addr[SA_W+1:2];
                            sram_wdata_q <= is_store_d ? wdata_d : '0;
                        end
                    end
                end
                ACCESS: begin
                    cnt_q <= WAIT_CNT;
                    if (WAIT_CNT != 4'd0) begin
                        state_q <= WAIT;
                    end else begin
                        state_q   <= DONE;
                        ready_q   <= 1'b1;
                        rd_gate_q <= is_load_q;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q   <= DONE;
                        ready_q   <= 1'b1;
                        rd_gate_q <= is_load_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // SRAM read data arrives in the DONE cycle itself, so the load result is
    // the SRAM output gated by a registered load-response flag; it is zero
    // in every other cycle.
    assign dmem_r_data = rd_gate_q ? sram_rdata : '0;
    assign dmem_ready  = ready_q;
    assign dmem_err    = err_q;
    assign sram_en     = sram_en_q;
    assign sram_we     = sram_we_q;
    assign sram_be     = sram_be_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait states and one
// with three, each attached to its own behavioural SRAM model.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_r, req_w;
    logic [1:0]  req_sz;
    logic [31:0] req_addr, req_data;
    int          sel;

    logic        r0, w0, r3, w3;
    assign r0 = (sel == 0) & req_r;
    assign w0 = (sel == 0) & req_w;
    assign r3 = (sel == 3) & req_r;
    assign w3 = (sel == 3) & req_w;

    logic [31:0] rdata0, wdata0, srd0, rdata3, wdata3, srd3;
    logic        rdy0, err0, en0, we0, rdy3, err3, en3, we3;
    logic [3:0]  be0, be3;
    logic [9:0]  saddr0, saddr3;

    dmem_ctrl #(.WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .dmem_addr(req_addr),
        .dmem_r_enable(r0), .dmem_w_enable(w0), .dmem_w_size(req_sz),
        .dmem_w_data(req_data), .dmem_r_data(rdata0), .dmem_ready(rdy0),
        .dmem_err(err0), .sram_en(en0), .sram_we(we0), .sram_be(be0),
        .sram_addr(saddr0), .sram_wdata(wdata0), .sram_rdata(srd0)
    );

    dmem_ctrl #(.WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .dmem_addr(req_addr),
        .dmem_r_enable(r3), .dmem_w_enable(w3), .dmem_w_size(req_sz),
        .dmem_w_data(req_data), .dmem_r_data(rdata3), .dmem_ready(rdy3),
        .dmem_err(err3), .sram_en(en3), .sram_we(we3), .sram_be(be3),
        .sram_addr(saddr3), .sram_wdata(wdata3), .sram_rdata(srd3)
    );

    // SRAM models: data is driven only in the exact valid cycle, garbage otherwise.
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic        v0;
    logic [31:0] d0;
    logic [3:0]  v3;
    logic [31:0] d3 [0:3];

    always @(posedge clk) begin
        if (en0) begin
            for (int b = 0; b < 4; b++)
                if (we0 && be0[b]) mem0[saddr0][8*b +: 8] <= wdata0[8*b +: 8];
            d0 <= mem0[saddr0];
        end
        v0 <= en0;
    end
    assign srd0 = v0 ? d0 : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (en3) begin
            for (int b = 0; b < 4; b++)
                if (we3 && be3[b]) mem3[saddr3][8*b +: 8] <= wdata3[8*b +: 8];
            d3[0] <= mem3[saddr3];
        end
        for (int s = 1; s < 4; s++) d3[s] <= d3[s-1];
        v3 <= {v3[2:0], en3};
    end
    assign srd3 = v3[3] ? d3[3] : 32'hBAD0_BAD0;

    // Monitor view of the selected instance.
    logic        m_en, m_we, m_rdy, m_err;
    logic [3:0]  m_be;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    assign m_en    = (sel == 3) ? en3    : en0;
    assign m_we    = (sel == 3) ? we3    : we0;
    assign m_rdy   = (sel == 3) ? rdy3   : rdy0;
    assign m_err   = (sel == 3) ? err3   : err0;
    assign m_be    = (sel == 3) ? be3    : be0;
    assign m_addr  = (sel == 3) ? saddr3 : saddr0;
    assign m_wdata = (sel == 3) ? wdata3 : wdata0;
    assign m_rdata = (sel == 3) ? rdata3 : rdata0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Observations of the last transaction (cycle 0 = request cycle).
    int          en_cnt, rdy_cnt, leak;
    int          en_k [0:3];
    int          rdy_k [0:3];
    logic        en_we, rdy_err;
    logic [3:0]  en_be;
    logic [9:0]  en_addr;
    logic [31:0] en_wdata, rdy_data;

    // Optional follow-on request presented the cycle after the first ready.
    logic        nxt_valid = 1'b0;
    logic        nxt_r, nxt_w;
    logic [1:0]  nxt_sz;
    logic [31:0] nxt_a, nxt_d;

    task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        req_r = r; req_w = w; req_sz = sz; req_addr = a; req_data = d;
    endtask

    task automatic run_req(input int s, input logic r, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d, input int ncyc);
        @(posedge clk); #1;
        sel = s;
        drive(r, w, sz, a, d);
        en_cnt = 0; rdy_cnt = 0; leak = 0;
        for (int i = 0; i < 4; i++) begin en_k[i] = -1; rdy_k[i] = -1; end
        en_we = 1'b0; en_be = '0; en_addr = '0; en_wdata = '0; rdy_err = 1'b0; rdy_data = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (m_en) begin
                if (en_cnt < 4) en_k[en_cnt] = k;
                if (en_cnt == 0) begin
                    en_we = m_we; en_be = m_be; en_addr = m_addr; en_wdata = m_wdata;
                end
                en_cnt++;
            end
            if (m_rdy) begin
                if (rdy_cnt < 4) rdy_k[rdy_cnt] = k;
                if (rdy_cnt == 0) begin rdy_err = m_err; rdy_data = m_rdata; end
                rdy_cnt++;
                @(posedge clk); #1;
                if (nxt_valid) begin
                    drive(nxt_r, nxt_w, nxt_sz, nxt_a, nxt_d);
                    nxt_valid = 1'b0;
                end else begin
                    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                end
            end else if (m_rdata != 32'h0) begin
                leak++;
            end
        end
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        $display("txn inst=w%0d r=%0b w=%0b sz=%0d addr=0x%h data=0x%h en_cnt=%0d en_cyc=%0d rdy_cyc=%0d err=%0b rdata=0x%h",
                 s, r, w, sz, a, d, en_cnt, en_k[0], rdy_k[0], rdy_err, rdy_data);
    endtask

    task automatic expect_txn(input string tag, input int e_en, input int e_rdy,
                              input logic e_err, input logic [31:0] e_data);
        chk({tag, ".en_cnt"}, en_cnt, (e_en >= 0) ? 1 : 0);
        if (e_en >= 0) chk({tag, ".en_cyc"}, en_k[0], e_en);
        chk({tag, ".rdy_cnt"}, rdy_cnt, 1);
        chk({tag, ".rdy_cyc"}, rdy_k[0], e_rdy);
        chk({tag, ".err"}, rdy_err, e_err);
        chk({tag, ".rdata"}, rdy_data, e_data);
        chk({tag, ".rdata_idle"}, leak, 0);
    endtask

    task automatic expect_acc(input string tag, input logic e_we, input logic [9:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata);
        chk({tag, ".we"}, en_we, e_we);
        chk({tag, ".addr"}, en_addr, e_addr);
        chk({tag, ".be"}, en_be, e_be);
        chk({tag, ".wdata"}, en_wdata, e_wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        reset = 1'b1;
        sel   = 0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ctl0",   {rdy0, err0, en0, we0, be0}, 32'h0);
        chk("rst.rdata0", rdata0, 32'h0);
        chk("rst.wdata0", wdata0, 32'h0);
        chk("rst.addr0",  saddr0, 32'h0);
        chk("rst.ctl3",   {rdy3, err3, en3, we3, be3}, 32'h0);
        chk("rst.rdata3", rdata3, 32'h0);
        chk("rst.wdata3", wdata3 | 32'(saddr3), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // No wait states: word, half and byte stores, loads, boundary address.
        run_req(0, 1'b0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 8);
        expect_txn("st_word", 1, 2, 1'b0, 32'h0);
        expect_acc("st_word", 1'b1, 10'd4, 4'b1111, 32'hDEAD_BEEF);

        run_req(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 8);
        expect_txn("ld_word", 1, 2, 1'b0, 32'hDEAD_BEEF);
        expect_acc("ld_word", 1'b0, 10'd4, 4'b0000, 32'h0);

        run_req(0, 1'b0, 1'b1, 2'b01, 32'h12, 32'hFFFF_1234, 8);
        expect_txn("st_half", 1, 2, 1'b0, 32'h0);
        expect_acc("st_half", 1'b1, 10'd4, 4'b1100, 32'h1234_1234);

        run_req(0, 1'b0, 1'b1, 2'b00, 32'h13, 32'h7777_77A5, 8);
        expect_txn("st_byte3", 1, 2, 1'b0, 32'h0);
        expect_acc("st_byte3", 1'b1, 10'd4, 4'b1000, 32'hA5A5_A5A5);

        run_req(0, 1'b0, 1'b1, 2'b00, 32'h10, 32'hFFFF_FF5A, 8);
        expect_txn("st_byte0", 1, 2, 1'b0, 32'h0);
        expect_acc("st_byte0", 1'b1, 10'd4, 4'b0001, 32'h5A5A_5A5A);

        run_req(0, 1'b1, 1'b0, 2'b00, 32'h12, 32'h0, 8);
        expect_txn("ld_merged", 1, 2, 1'b0, 32'hA534_BE5A);
        expect_acc("ld_merged", 1'b0, 10'd4, 4'b0000, 32'h0);

        run_req(0, 1'b0, 1'b1, 2'b10, 32'hFFC, 32'h0BAD_CAFE, 8);
        expect_txn("st_top", 1, 2, 1'b0, 32'h0);
        expect_acc("st_top", 1'b1, 10'h3FF, 4'b1111, 32'h0BAD_CAFE);
        run_req(0, 1'b1, 1'b0, 2'b00, 32'hFFD, 32'h0, 8);
        expect_txn("ld_top", 1, 2, 1'b0, 32'h0BAD_CAFE);

        // Rejected requests: ready+err one cycle later, no SRAM access.
        run_req(0, 1'b0, 1'b1, 2'b01, 32'h11, 32'h1111, 8);
        expect_txn("err_half", -1, 1, 1'b1, 32'h0);
        run_req(0, 1'b0, 1'b1, 2'b10, 32'h22, 32'h2222, 8);
        expect_txn("err_word", -1, 1, 1'b1, 32'h0);
        run_req(0, 1'b0, 1'b1, 2'b11, 32'h20, 32'h3333, 8);
        expect_txn("err_size", -1, 1, 1'b1, 32'h0);
        run_req(0, 1'b1, 1'b1, 2'b10, 32'h20, 32'h4444, 8);
        expect_txn("err_rw", -1, 1, 1'b1, 32'h0);
        run_req(0, 1'b1, 1'b0, 2'b00, 32'h1000, 32'h0, 8);
        expect_txn("err_range", -1, 1, 1'b1, 32'h0);
        run_req(0, 1'b0, 1'b1, 2'b00, 32'hFFFF_FFF0, 32'h55, 8);
        expect_txn("err_range_hi", -1, 1, 1'b1, 32'h0);

        // Back-to-back, no wait states: second access 3 cycles after the first.
        nxt_r = 1'b1; nxt_w = 1'b0; nxt_sz = 2'b00; nxt_a = 32'h44; nxt_d = 32'h0;
        nxt_valid = 1'b1;
        run_req(0, 1'b0, 1'b1, 2'b10, 32'h44, 32'h1122_3344, 12);
        chk("b2b0.en_cnt",  en_cnt, 2);
        chk("b2b0.en_gap",  en_k[1] - en_k[0], 3);
        chk("b2b0.rdy_cnt", rdy_cnt, 2);
        chk("b2b0.rdy2",    rdy_k[1], 5);

        // Three wait states.
        run_req(3, 1'b0, 1'b1, 2'b10, 32'h20, 32'hCAFE_F00D, 10);
        expect_txn("w3_st", 1, 5, 1'b0, 32'h0);
        expect_acc("w3_st", 1'b1, 10'd8, 4'b1111, 32'hCAFE_F00D);
        run_req(3, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 10);
        expect_txn("w3_ld", 1, 5, 1'b0, 32'hCAFE_F00D);
        run_req(3, 1'b0, 1'b1, 2'b10, 32'h22, 32'h0, 10);
        expect_txn("w3_err", -1, 1, 1'b1, 32'h0);

        nxt_r = 1'b1; nxt_w = 1'b0; nxt_sz = 2'b00; nxt_a = 32'h20; nxt_d = 32'h0;
        nxt_valid = 1'b1;
        run_req(3, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 16);
        chk("b2b3.en_cnt",  en_cnt, 2);
        chk("b2b3.en_gap",  en_k[1] - en_k[0], 6);
        chk("b2b3.rdy_cnt", rdy_cnt, 2);

        // Reset during WAIT of a load: outputs clear, no ready pulse.
        @(posedge clk); #1;
        sel = 3;
        drive(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);      // cycle 0
        @(negedge clk); @(negedge clk);               // cycle 1
        chk("rstmid.en", en3, 1'b1);
        @(negedge clk);                               // cycle 2 (WAIT)
        @(posedge clk); #1;                           // cycle 3 (WAIT)
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk); @(negedge clk);               // cycle 4
        chk("rstmid.ctl",   {rdy3, err3, en3, we3, be3}, 32'h0);
        chk("rstmid.rdata", rdata3, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        rdy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdy3) rdy_seen++;
        end
        chk("rstmid.no_rdy", rdy_seen, 0);

        run_req(3, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 10);
        expect_txn("rstmid.fresh", 1, 5, 1'b0, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
